// File: rtl/fifo_axi_write_issuer_pkg.sv
// axi_pkg: shared AXI encodings, issuer state type and command-FIFO field offsets.
// Command entry layout, LSB first: burst[1:0], size[4:2], len[12:5], addr, then id in the top bits.
package axi_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    localparam int AWF_BURST_LSB = 0;
    localparam int AWF_SIZE_LSB  = 2;
    localparam int AWF_LEN_LSB   = 5;
    localparam int AWF_ADDR_LSB  = 13;
endpackage

// File: rtl/fifo_axi_write_issuer_if.sv
// fifo_axi_write_issuer_if: FIFO-side and AXI write-channel signals of the write issuer.
// master: issuer view (pops command/data FIFOs, drives AW/W, accepts B, pushes response FIFO).
// slave: environment view (FIFOs and AXI slave).
interface fifo_axi_write_issuer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    localparam int AWF_WIDTH = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;
    localparam int WF_WIDTH  = DATA_WIDTH + DATA_WIDTH / 8;

    logic [AWF_WIDTH-1:0]    aw_fifo_head;
    logic                    aw_fifo_empty;
    logic                    aw_fifo_read_en;
    logic [WF_WIDTH-1:0]     w_fifo_head;
    logic                    w_fifo_empty;
    logic                    w_fifo_read_en;
    logic [ID_WIDTH+1:0]     b_fifo_data_in;
    logic                    b_fifo_full;
    logic                    b_fifo_write_en;
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic                    busy;

    modport master (
        input  aw_fifo_head, aw_fifo_empty, w_fifo_head, w_fifo_empty, b_fifo_full,
               awready, wready, bid, bresp, bvalid,
        output aw_fifo_read_en, w_fifo_read_en, b_fifo_data_in, b_fifo_write_en,
               awid, awaddr, awlen, awsize, awburst, awvalid,
               wdata, wstrb, wlast, wvalid, bready, busy
    );

    modport slave (
        output aw_fifo_head, aw_fifo_empty, w_fifo_head, w_fifo_empty, b_fifo_full,
               awready, wready, bid, bresp, bvalid,
        input  aw_fifo_read_en, w_fifo_read_en, b_fifo_data_in, b_fifo_write_en,
               awid, awaddr, awlen, awsize, awburst, awvalid,
               wdata, wstrb, wlast, wvalid, bready, busy
    );
endinterface

// File: rtl/fifo_axi_write_issuer.sv
// fifo_axi_write_issuer: pops commands/beats from FIFOs and issues one AXI4 write at a time.
// Ports: clk (rising edge), clr (async active-low reset), bus (fifo_axi_write_issuer_if.master:
// command/data/response FIFO handshakes, AW/W/B channels, busy).
module fifo_axi_write_issuer
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int AWF_WIDTH  = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2,
    parameter int WF_WIDTH   = DATA_WIDTH + DATA_WIDTH / 8
) (
    input logic clk,
    input logic clr,
    fifo_axi_write_issuer_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_t                state;
    logic                  awvalid_q;
    logic [ID_WIDTH-1:0]   awid_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [7:0]            awlen_q;
    logic [2:0]            awsize_q;
    logic [1:0]            awburst_q;
    logic [8:0]            beat_cnt;
    logic                  in_data;
    logic                  wvalid;
    logic                  wlast;
    logic                  w_hs;
    logic                  bready;
    logic                  b_hs;

    assign in_data = state == DATA;
    assign wvalid  = in_data && !bus.w_fifo_empty;
    assign wlast   = in_data && beat_cnt == {1'b0, awlen_q};
    assign w_hs    = wvalid && bus.wready;
    assign bready  = state == RESP && !bus.b_fifo_full;
    assign b_hs    = bready && bus.bvalid;

    assign bus.aw_fifo_read_en = state == IDLE && !bus.aw_fifo_empty;
    assign bus.w_fifo_read_en  = w_hs;
    assign bus.b_fifo_write_en = b_hs;
    // Response is forwarded straight from the slave; zeroed outside RESP so idle outputs read 0.
    assign bus.b_fifo_data_in  = state == RESP ? {bus.bid, bus.bresp} : '0;
    assign bus.awvalid = awvalid_q;
    assign bus.awid    = awid_q;
    assign bus.awaddr  = awaddr_q;
    assign bus.awlen   = awlen_q;
    assign bus.awsize  = awsize_q;
    assign bus.awburst = awburst_q;
    assign bus.wdata   = in_data ? bus.w_fifo_head[WF_WIDTH-1 -: DATA_WIDTH] : '0;
    assign bus.wstrb   = in_data ? bus.w_fifo_head[STRB_WIDTH-1:0] : '0;
    assign bus.wlast   = wlast;
    assign bus.wvalid  = wvalid;
    assign bus.bready  = bready;
    assign bus.busy    = state != IDLE;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            awvalid_q <= 1'b0;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (!bus.aw_fifo_empty) begin
                    awid_q    <= bus.aw_fifo_head[AWF_WIDTH-1 -: ID_WIDTH];
                    awaddr_q  <= bus.aw_fifo_head[AWF_ADDR_LSB +: ADDR_WIDTH];
                    awlen_q   <= bus.aw_fifo_head[AWF_LEN_LSB +: 8];
                    awsize_q  <= bus.aw_fifo_head[AWF_SIZE_LSB +: 3];
                    awburst_q <= bus.aw_fifo_head[AWF_BURST_LSB +: 2];
                    awvalid_q <= 1'b1;
                    state     <= ADDR;
                end
                ADDR: if (bus.awready) begin
                    awvalid_q <= 1'b0;
                    beat_cnt  <= '0;
                    state     <= DATA;
                end
                // 9-bit counter: a 256-beat burst ends at 255 and the increment cannot wrap.
                DATA: if (w_hs) begin
                    beat_cnt <= beat_cnt + 9'd1;
                    if (wlast) state <= RESP;
                end
                default: if (b_hs) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_axi_write_issuer.sv
// tb_fifo_axi_write_issuer: scenario tasks with queue-based FIFO/slave models and expected-transaction lists.
module tb_fifo_axi_write_issuer;
    import axi_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IW  = 4;
    localparam int AWF = IW + AW + 13;
    localparam int WF  = DW + DW / 8;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    fifo_axi_write_issuer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    fifo_axi_write_issuer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [AWF-1:0]  aw_q[$], aw_log[$], exp_aw[$];
    logic [WF-1:0]   w_q[$], w_hold[$];
    logic [WF:0]     w_log[$], exp_w[$];
    logic [IW+1:0]   resp_q[$], b_log[$], exp_b[$];
    bit              b_pending, rand_mode, w_toggle;

    logic            s_awvalid, s_wvalid, s_wlast, s_bready, s_bvalid, s_push, s_busy, s_aw_pop, s_w_pop;
    logic [AW-1:0]   s_awaddr;
    logic [DW-1:0]   s_wdata;
    logic [IW+1:0]   s_bdata;

    function automatic logic [98:0] outs();
        return {bus.awvalid, bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst,
                bus.wvalid, bus.wlast, bus.wdata, bus.wstrb, bus.bready, bus.b_fifo_write_en,
                bus.b_fifo_data_in, bus.busy, bus.aw_fifo_read_en, bus.w_fifo_read_en};
    endfunction

    task automatic refresh();
        bus.aw_fifo_empty = aw_q.size() == 0;
        bus.aw_fifo_head  = aw_q.size() != 0 ? aw_q[0] : '0;
        bus.w_fifo_empty  = w_q.size() == 0;
        bus.w_fifo_head   = w_q.size() != 0 ? w_q[0] : '0;
        bus.bvalid        = b_pending && resp_q.size() != 0;
        {bus.bid, bus.bresp} = resp_q.size() != 0 ? resp_q[0] : '0;
    endtask

    task automatic reset_logs();
        aw_log.delete(); w_log.delete(); b_log.delete();
        exp_aw.delete(); exp_w.delete(); exp_b.delete();
    endtask

    // Enqueue one command, its len+1 beats and the slave's planned response, plus the expected trace.
    task automatic push_cmd(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [IW-1:0] bid, input logic [1:0] resp, input bit hold);
        logic [AWF-1:0] c;
        logic [WF-1:0]  d;
        c = {id, addr, len, 3'($urandom), 2'($urandom)};
        aw_q.push_back(c);
        exp_aw.push_back(c);
        for (int i = 0; i <= int'(len); i++) begin
            d = {$urandom, 4'($urandom)};
            if (hold) w_hold.push_back(d); else w_q.push_back(d);
            exp_w.push_back({d, 1'(i == int'(len))});
        end
        resp_q.push_back({bid, resp});
        exp_b.push_back({bid, resp});
        refresh();
    endtask

    // One clock: sample/log at negedge, then apply FIFO pops and slave updates just after posedge.
    task automatic cycle();
        @(negedge clk);
        s_awvalid = bus.awvalid; s_awaddr = bus.awaddr;
        s_wvalid  = bus.wvalid;  s_wlast  = bus.wlast;  s_wdata = bus.wdata;
        s_bready  = bus.bready;  s_bvalid = bus.bvalid;
        s_push    = bus.b_fifo_write_en; s_bdata = bus.b_fifo_data_in;
        s_busy    = bus.busy;    s_aw_pop = bus.aw_fifo_read_en; s_w_pop = bus.w_fifo_read_en;
        if (bus.awvalid && bus.awready) aw_log.push_back({bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst});
        if (s_w_pop) w_log.push_back({bus.wdata, bus.wstrb, bus.wlast});
        if (s_push) b_log.push_back(s_bdata);
        @(posedge clk);
        #1;
        if (s_aw_pop && aw_q.size() != 0) void'(aw_q.pop_front());
        if (s_w_pop && w_q.size() != 0) void'(w_q.pop_front());
        if (s_w_pop && s_wlast) b_pending = 1'b1;
        if (s_push) begin
            b_pending = 1'b0;
            if (resp_q.size() != 0) void'(resp_q.pop_front());
        end
        if (rand_mode) begin
            bus.awready     = 1'($urandom);
            bus.wready      = 1'($urandom);
            bus.b_fifo_full = $urandom_range(0, 3) == 0;
            if (w_hold.size() != 0 && 1'($urandom)) w_q.push_back(w_hold.pop_front());
        end
        if (w_toggle) bus.wready = !bus.wready;
        refresh();
    endtask

    task automatic test_reset();
        bus.awready = 1'b1; bus.wready = 1'b1; bus.b_fifo_full = 1'b0;
        refresh();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (outs() !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", outs());
        end
        bus.aw_fifo_empty = 1'b0;
        #1;
        n_cmp++;
        if (bus.aw_fifo_read_en !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_aw_pop_follows_empty: got %b want 1", bus.aw_fifo_read_en);
        end
        refresh();
        @(posedge clk);
        #1;
        clr = 1'b1;
    endtask

    task automatic test_single_beat();
        reset_logs();
        aw_q.push_back({4'd3, 32'h1000, 8'd0, 3'd2, BURST_INCR});
        w_q.push_back({32'hDEADBEEF, 4'hF});
        resp_q.push_back({4'd3, RESP_OKAY});
        refresh();
        cycle();
        n_cmp++;
        if ({s_aw_pop, s_busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL single_c0_pop: got pop/busy %b%b want 10", s_aw_pop, s_busy);
        end
        cycle();
        n_cmp++;
        if ({s_awvalid, s_awaddr} !== {1'b1, 32'h1000}) begin
            n_bad++;
            $display("FAIL single_c1_aw: got valid %b addr %h want 1 1000", s_awvalid, s_awaddr);
        end
        cycle();
        n_cmp++;
        if ({s_wvalid, s_wlast, s_w_pop, s_wdata} !== {3'b111, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL single_c2_w: got v/l/pop %b%b%b data %h want 111 deadbeef", s_wvalid, s_wlast, s_w_pop, s_wdata);
        end
        cycle();
        n_cmp++;
        if ({s_push, s_bdata} !== {1'b1, 4'd3, RESP_OKAY}) begin
            n_bad++;
            $display("FAIL single_c3_push: got %b %h want 1 %h", s_push, s_bdata, {4'd3, RESP_OKAY});
        end
        cycle();
        n_cmp++;
        if ({s_busy, s_push} !== 2'b00) begin
            n_bad++;
            $display("FAIL single_c4_idle: got busy/push %b%b want 00", s_busy, s_push);
        end
    endtask

    task automatic test_burst_wready_toggle();
        int pops;
        reset_logs();
        push_cmd(4'd5, $urandom, 8'd3, 4'd5, RESP_OKAY, 1'b0);
        cycle();
        cycle();
        bus.wready = 1'b1;
        w_toggle = 1'b1;
        pops = 0;
        for (int k = 0; k < 40 && b_log.size() < 1; k++) begin
            cycle();
            if (s_w_pop) pops++;
        end
        w_toggle = 1'b0;
        bus.wready = 1'b1;
        n_cmp++;
        if (pops != 4 || w_log.size() != 4) begin
            n_bad++;
            $display("FAIL burst_beat_count: got pops %0d logged %0d want 4", pops, w_log.size());
        end
        for (int i = 0; i < 4 && i < w_log.size(); i++) begin
            n_cmp++;
            if (w_log[i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL burst_beat%0d: got %h want %h", i, w_log[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_awready_stall();
        logic [AW-1:0] a;
        a = 32'hA5A5_0040;
        reset_logs();
        bus.awready = 1'b0;
        push_cmd(4'd9, a, 8'd1, 4'd9, RESP_OKAY, 1'b0);
        cycle();
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_cmp++;
            if ({s_awvalid, s_awaddr, s_wvalid, s_w_pop} !== {1'b1, a, 2'b00}) begin
                n_bad++;
                $display("FAIL aw_stall_cyc%0d: got v %b addr %h wv %b pop %b want 1 %h 0 0", k, s_awvalid, s_awaddr, s_wvalid, s_w_pop, a);
            end
        end
        bus.awready = 1'b1;
        for (int k = 0; k < 30 && b_log.size() < 1; k++) cycle();
        n_cmp++;
        if (aw_log.size() != 1 || aw_log[0] !== exp_aw[0] || w_log.size() != 2) begin
            n_bad++;
            $display("FAIL aw_stall_done: got aw %0d beats %0d want 1 2", aw_log.size(), w_log.size());
        end
    endtask

    task automatic test_w_empty_stall();
        reset_logs();
        push_cmd(4'd6, $urandom, 8'd1, 4'd6, RESP_EXOKAY, 1'b1);
        cycle();
        cycle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_cmp++;
            if ({s_wvalid, s_w_pop, s_wlast, s_busy} !== 4'b0001) begin
                n_bad++;
                $display("FAIL w_stall_cyc%0d: got v/pop/last/busy %b%b%b%b want 0001", k, s_wvalid, s_w_pop, s_wlast, s_busy);
            end
        end
        while (w_hold.size() != 0) w_q.push_back(w_hold.pop_front());
        refresh();
        for (int k = 0; k < 30 && b_log.size() < 1; k++) cycle();
        n_cmp++;
        if (w_log.size() != 2 || w_log[0] !== exp_w[0] || w_log[1] !== exp_w[1] || b_log.size() != 1 || b_log[0] !== exp_b[0]) begin
            n_bad++;
            $display("FAIL w_stall_done: got beats %0d resp %0d want 2 1", w_log.size(), b_log.size());
        end
    endtask

    task automatic test_b_full();
        reset_logs();
        bus.b_fifo_full = 1'b1;
        push_cmd(4'hC, $urandom, 8'd0, 4'hC, RESP_SLVERR, 1'b0);
        cycle();
        cycle();
        cycle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_cmp++;
            if ({s_bvalid, s_bready, s_push} !== 3'b100) begin
                n_bad++;
                $display("FAIL b_full_cyc%0d: got bvalid/bready/push %b%b%b want 100", k, s_bvalid, s_bready, s_push);
            end
        end
        bus.b_fifo_full = 1'b0;
        cycle();
        n_cmp++;
        if ({s_push, s_bdata} !== {1'b1, 4'hC, RESP_SLVERR}) begin
            n_bad++;
            $display("FAIL b_full_push: got %b %h want 1 %h", s_push, s_bdata, {4'hC, RESP_SLVERR});
        end
        cycle();
        n_cmp++;
        if ({s_busy, s_push} !== 2'b00 || b_log.size() != 1) begin
            n_bad++;
            $display("FAIL b_full_idle: got busy/push %b%b pushes %0d want 00 1", s_busy, s_push, b_log.size());
        end
    endtask

    task automatic test_reset_mid();
        bit popped;
        reset_logs();
        push_cmd(4'd7, $urandom, 8'd7, 4'd7, RESP_OKAY, 1'b0);
        for (int k = 0; k < 40 && w_log.size() < 2; k++) cycle();
        clr = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %h want 0", outs());
        end
        popped = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            popped |= s_w_pop | s_aw_pop | s_push;
        end
        n_cmp++;
        if (popped !== 1'b0 || w_log.size() != 2) begin
            n_bad++;
            $display("FAIL midreset_no_pops: got popped %b beats %0d want 0 2", popped, w_log.size());
        end
        aw_q.delete(); w_q.delete(); resp_q.delete(); w_hold.delete();
        b_pending = 1'b0;
        reset_logs();
        refresh();
        clr = 1'b1;
        push_cmd(4'd2, $urandom, 8'd2, 4'd2, RESP_DECERR, 1'b0);
        for (int k = 0; k < 30 && b_log.size() < 1; k++) cycle();
        n_cmp++;
        if (aw_log.size() != 1 || aw_log[0] !== exp_aw[0] || w_log.size() != 3 || b_log.size() != 1 || b_log[0] !== exp_b[0]) begin
            n_bad++;
            $display("FAIL midreset_next_txn: got aw %0d beats %0d resp %0d want 1 3 1", aw_log.size(), w_log.size(), b_log.size());
        end
        for (int i = 0; i < 3 && i < w_log.size(); i++) begin
            n_cmp++;
            if (w_log[i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL midreset_beat%0d: got %h want %h", i, w_log[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_random();
        localparam int N = 25;
        reset_logs();
        for (int t = 0; t < N; t++)
            push_cmd(4'($urandom), $urandom, 8'($urandom_range(0, 7)), 4'($urandom), 2'($urandom), 1'b1);
        rand_mode = 1'b1;
        for (int k = 0; k < 6000 && b_log.size() < N; k++) cycle();
        rand_mode = 1'b0;
        bus.awready = 1'b1; bus.wready = 1'b1; bus.b_fifo_full = 1'b0;
        n_cmp++;
        if (aw_log.size() != exp_aw.size() || w_log.size() != exp_w.size() || b_log.size() != exp_b.size()) begin
            n_bad++;
            $display("FAIL random_counts: got aw %0d w %0d b %0d want %0d %0d %0d",
                     aw_log.size(), w_log.size(), b_log.size(), exp_aw.size(), exp_w.size(), exp_b.size());
        end
        for (int i = 0; i < aw_log.size() && i < exp_aw.size(); i++) begin
            n_cmp++;
            if (aw_log[i] !== exp_aw[i]) begin
                n_bad++;
                $display("FAIL random_aw%0d: got %h want %h", i, aw_log[i], exp_aw[i]);
            end
        end
        for (int i = 0; i < w_log.size() && i < exp_w.size(); i++) begin
            n_cmp++;
            if (w_log[i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL random_w%0d: got %h want %h", i, w_log[i], exp_w[i]);
            end
        end
        for (int i = 0; i < b_log.size() && i < exp_b.size(); i++) begin
            n_cmp++;
            if (b_log[i] !== exp_b[i]) begin
                n_bad++;
                $display("FAIL random_b%0d: got %h want %h", i, b_log[i], exp_b[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_burst_wready_toggle();
        test_awready_stall();
        test_w_empty_stall();
        test_b_full();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
